// File: rtl/cache_data_array.sv
// ---------------------------------------------------------------------------
// cache_data_array
//
// Data storage for a set-associative cache. It holds WAYS*SETS lines of DW
// bits, with one valid bit per line. It provides byte-enabled writes, reads
// with a 1-cycle registered latency, and a background flush that invalidates
// one set per cycle.
//
// Parameters
//   DW    line width in bits (multiple of 8, >= 8)
//   SETS  sets per way (power of two, >= 2)
//   WAYS  number of ways (power of two, >= 1)
//
// Ports
//   clk            clock; all state updates on the rising edge
//   rst            asynchronous, active-low reset
//   rd_en          read request (ignored while busy)
//   rd_set/rd_way  read index
//   rd_data        registered read data; holds its value when rd_vld=0
//   rd_vld         rd_data/rd_line_valid belong to the read accepted last cycle
//   rd_line_valid  valid bit of the line that was read
//   wr_en          write request (ignored while busy)
//   wr_set/wr_way  write index
//   wr_be          byte enables; bit i covers wr_data[8i+7:8i]
//   wr_data        write data
//   flush_req      one-cycle pulse that starts invalidation of all lines
//   busy           a flush is in progress
//
// Configuration
//   CACHE_DATA_ARRAY_BYPASS_EN  when defined, a read and a write to the same
//                               line in the same cycle return the merged
//                               (post-write) line. When undefined, the read
//                               returns the pre-write line.
// ---------------------------------------------------------------------------
module cache_data_array #(
  parameter int DW   = 128,
  parameter int SETS = 8,
  parameter int WAYS = 2,
  localparam int SW  = $clog2(SETS),
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int BW  = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [SW-1:0] rd_set,
  input  logic [WW-1:0] rd_way,
  output logic [DW-1:0] rd_data,
  output logic          rd_vld,
  output logic          rd_line_valid,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_set,
  input  logic [WW-1:0] wr_way,
  input  logic [BW-1:0] wr_be,
  input  logic [DW-1:0] wr_data,
  input  logic          flush_req,
  output logic          busy
);

  localparam int LINES = WAYS * SETS;
  localparam int LW    = $clog2(LINES);

  // Parameter checks at elaboration time.
  if (DW < 8 || (DW % 8) != 0) begin : g_bad_dw
    $error("cache_data_array: DW must be a multiple of 8 and at least 8");
  end
  if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
    $error("cache_data_array: SETS must be a power of two and at least 2");
  end
  if (WAYS < 1 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
    $error("cache_data_array: WAYS must be a power of two and at least 1");
  end

  typedef enum logic {IDLE, FLUSH} state_t;

  // Both dimensions are powers of two, so the line number is {way, set}.
  // With a single way, the way bit is dropped.
  function automatic logic [LW-1:0] line_idx(input logic [SW-1:0] set,
                                             input logic [WW-1:0] way);
    if (WAYS > 1) return LW'({way, set});
    else          return LW'(set);
  endfunction

  logic [DW-1:0]    mem [LINES];
  logic [LINES-1:0] valid;
  state_t           state, state_nxt;
  logic [SW-1:0]    cnt;

  logic          rd_acc, wr_acc, wr_any;
  logic [LW-1:0] rd_idx, wr_idx;
  logic [DW-1:0] rd_data_nxt;
  logic          rd_lv_nxt;

  assign busy   = (state == FLUSH);
  assign rd_acc = rd_en & ~busy;
  assign wr_acc = wr_en & ~busy;
  assign wr_any = wr_acc & (|wr_be);
  assign rd_idx = line_idx(rd_set, rd_way);
  assign wr_idx = line_idx(wr_set, wr_way);

  // ---------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state elements use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order of the always blocks.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: give every always_comb output a default first. Any path that
    // leaves an output unassigned would infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:  if (flush_req)               state_nxt = FLUSH;
      FLUSH: if (cnt == SW'(SETS - 1))    state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // The set counter wraps to 0 after SETS-1 because SETS is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           cnt <= '0;
    else if (state == IDLE && flush_req) cnt <= '0;
    else if (state == FLUSH)             cnt <= cnt + SW'(1);
  end

  // ---------------------------------------------------------------------
  // Valid bits: cleared by reset and by flush, set by a non-empty write.
  // A flush and an accepted write never coincide, because writes are
  // ignored while busy.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (busy) begin
      for (int w = 0; w < WAYS; w++) valid[line_idx(cnt, WW'(w))] <= 1'b0;
    end else if (wr_any) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Line storage
  // ---------------------------------------------------------------------
  // NOTE: the data array has no reset. The valid bits alone decide what a
  // read returns, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < BW; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read path. An invalid line reads back as all-zero.
  // ---------------------------------------------------------------------
  always_comb begin
    rd_lv_nxt   = valid[rd_idx];
    rd_data_nxt = valid[rd_idx] ? mem[rd_idx] : '0;
`ifdef CACHE_DATA_ARRAY_BYPASS_EN
    if (wr_any && (wr_idx == rd_idx)) begin
      for (int b = 0; b < BW; b++) begin
        if (wr_be[b]) rd_data_nxt[8*b +: 8] = wr_data[8*b +: 8];
      end
      rd_lv_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld        <= 1'b0;
      rd_data       <= '0;
      rd_line_valid <= 1'b0;
    end else begin
      rd_vld <= rd_acc;
      if (rd_acc) begin
        rd_data       <= rd_data_nxt;
        rd_line_valid <= rd_lv_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cache_data_array.sv
// ---------------------------------------------------------------------------
// tb_cache_data_array
//
// Directed bench for cache_data_array with its default parameters
// (DW=128, SETS=8, WAYS=2). Each read that should be accepted pushes its
// expected result, taken from a reference model, onto a queue. After every
// rising edge, a registered result is popped and compared. When the queue
// is empty, the bench requires rd_vld=0 and rd_data to hold its last value.
// ---------------------------------------------------------------------------
module tb_cache_data_array;

  localparam int DW = 128, SETS = 8, WAYS = 2, BW = DW / 8, LINES = SETS * WAYS;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en, wr_en, flush_req;
  logic [2:0]    rd_set, wr_set;
  logic [0:0]    rd_way, wr_way;
  logic [BW-1:0] wr_be;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_vld, rd_line_valid, busy;

  cache_data_array #(.DW(DW), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_set(rd_set), .rd_way(rd_way),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_line_valid(rd_line_valid),
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way),
    .wr_be(wr_be), .wr_data(wr_data),
    .flush_req(flush_req), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          lv;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_mem [LINES];
  logic          m_vld [LINES];
  logic [DW-1:0] last_data;
  int            n_checks = 0;
  int            n_errors = 0;
  int            busy_cnt;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input int set, input int way);
    return way * SETS + set;
  endfunction

  // Drive a read and record its expected result from the model state before
  // any write issued in the same cycle.
  task automatic issue_read(input int set, input int way);
    exp_t e;
    rd_en  = 1'b1;
    rd_set = 3'(set);
    rd_way = 1'(way);
    e.lv   = m_vld[idx(set, way)];
    e.d    = e.lv ? m_mem[idx(set, way)] : '0;
    sb.push_back(e);
  endtask

  // Drive a write and apply it to the model (used only when it is accepted).
  task automatic issue_write(input int set, input int way, input logic [BW-1:0] be,
                             input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_set  = 3'(set);
    wr_way  = 1'(way);
    wr_be   = be;
    wr_data = data;
    for (int b = 0; b < BW; b++)
      if (be[b]) m_mem[idx(set, way)][8*b +: 8] = data[8*b +: 8];
    if (be != '0) m_vld[idx(set, way)] = 1'b1;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".rd_vld"}, DW'(rd_vld), DW'(1));
      check({tag, ".rd_data"}, rd_data, e.d);
      check({tag, ".rd_line_valid"}, DW'(rd_line_valid), DW'(e.lv));
      last_data = e.d;
    end else begin
      check({tag, ".rd_vld_idle"}, DW'(rd_vld), DW'(0));
      check({tag, ".rd_data_hold"}, rd_data, last_data);
    end
    rd_en = 1'b0; wr_en = 1'b0; flush_req = 1'b0; wr_be = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) m_vld[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; flush_req = 1'b0;
    rd_set = '0; rd_way = '0; wr_set = '0; wr_way = '0; wr_be = '0; wr_data = '0;
    last_data = '0;
    for (int i = 0; i < LINES; i++) begin m_mem[i] = '0; m_vld[i] = 1'b0; end

    // Reset values
    #12;
    check("reset.rd_data", rd_data, '0);
    check("reset.rd_vld", DW'(rd_vld), DW'(0));
    check("reset.rd_line_valid", DW'(rd_line_valid), DW'(0));
    check("reset.busy", DW'(busy), DW'(0));
    @(negedge clk); rst = 1'b1;

    // Read of a never-written line: zero data, invalid
    issue_read(3, 1);   tick("rd_empty");
    tick("idle0");

    // Full-line write, then read back
    issue_write(2, 0, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF); tick("wr_full");
    issue_read(2, 0);   tick("rd_full");
    tick("idle1");

    // Top byte and byte 0 only
    issue_write(2, 0, 16'h8001, {DW{1'b1}}); tick("wr_8001");
    issue_read(2, 0);   tick("rd_8001");

    // Same-line read and write in the same cycle
`ifdef CACHE_DATA_ARRAY_BYPASS_EN
    begin
      exp_t e;
      rd_en = 1'b1; rd_set = 3'd5; rd_way = 1'd1;
      e.d = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}; e.lv = 1'b1;
      sb.push_back(e);
    end
`else
    issue_read(5, 1);
`endif
    issue_write(5, 1, 16'h00FF, {DW{1'b1}});
    tick("collide");

    // A zero byte-enable write changes nothing
    issue_write(6, 0, 16'h0000, {DW{1'b1}}); tick("wr_be0");
    issue_read(6, 0);   tick("rd_be0");

    // Read and write to different lines in the same cycle
    issue_read(2, 0);
    issue_write(4, 1, 16'hFFFF, 128'hDEADBEEF_00112233_44556677_8899AABB);
    tick("rw_diff");
    issue_read(4, 1);   tick("rd_diff");

    // Fill every line with random data and read all of them back
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        issue_write(s, w, 16'hFFFF, d); tick("fill");
      end
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        issue_read(s, w); tick("rd_fill");
      end

    // Flush. A read in the same cycle as flush_req executes normally.
    issue_read(0, 0);
    flush_req = 1'b1;
    tick("flush_start");
    clear_model();
    busy_cnt = busy ? 1 : 0;
    // Everything driven while busy is ignored: no result is queued, and the
    // write must not be applied (it would revalidate set 1 way 0).
    for (int k = 0; k < SETS; k++) begin
      rd_en = 1'b1; rd_set = 3'd1; rd_way = 1'd0;
      wr_en = 1'b1; wr_set = 3'd1; wr_way = 1'd0; wr_be = 16'hFFFF; wr_data = {DW{1'b1}};
      flush_req = 1'b1;
      tick("flush_busy");
      if (busy) busy_cnt++;
    end
    check("flush.busy_cycles", DW'(busy_cnt), DW'(SETS));
    check("flush.busy_end", DW'(busy), DW'(0));
    tick("post_flush");
    check("flush.no_retrigger", DW'(busy), DW'(0));
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        issue_read(s, w); tick("rd_flushed");
      end

    // Reset in the middle of a flush
    issue_write(0, 0, 16'hFFFF, 128'h1); tick("pre_rst_w0");
    issue_write(7, 1, 16'hFFFF, 128'h2); tick("pre_rst_w1");
    flush_req = 1'b1; tick("flush2_start");
    tick("flush2_c1");
    tick("flush2_c2");
    check("flush2.busy", DW'(busy), DW'(1));
    rst = 1'b0;
    #1;
    check("midrst.busy", DW'(busy), DW'(0));
    check("midrst.rd_vld", DW'(rd_vld), DW'(0));
    check("midrst.rd_data", rd_data, '0);
    clear_model();
    last_data = '0;
    @(negedge clk); rst = 1'b1;
    tick("post_rst");
    check("postrst.busy", DW'(busy), DW'(0));
    issue_read(7, 1);   tick("rd_postrst_71");
    issue_read(0, 0);   tick("rd_postrst_00");
    check("postrst.idle", DW'(busy), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
